// File: rtl/mac_pkg.sv
// Shared definitions for the multiply-accumulate datapath: state encoding,
// default sizing and the product width shared with the multiplier.
package mac_pkg;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_DONE  = 1'b1
  } mac_state_e;

  localparam int MAC_N_TERMS_DEF = 4;
  localparam int MAC_ACC_W_DEF   = 16;
  localparam int MAC_PROD_W      = 8;

endpackage

// File: rtl/mac_term_counter.sv
// 8-bit frame term counter: counts accepted products, wraps to 0 on the
// last term of a frame, and flags when the next accept closes the frame.
module mac_term_counter #(
  parameter int N_TERMS = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       clr,
  input  logic       inc,
  output logic [7:0] cnt,
  output logic       last
);

  localparam logic [7:0] LAST_IDX = 8'(N_TERMS - 1);

  assign last = (cnt == LAST_IDX);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= 8'd0;
    end else if (clr) begin
      cnt <= 8'd0;
    end else if (inc) begin
      cnt <= last ? 8'd0 : cnt + 8'd1;
    end
  end

endmodule

// File: rtl/mac_accumulator.sv
// Sums N_TERMS unsigned products per frame into an ACC_W-bit accumulator and
// presents the sum with a sticky overflow flag over a valid/ready handshake.
//
// state    | meaning
// ST_ACCUM | accepting products, one per cycle
// ST_DONE  | frame complete, holding acc_sum/overflow until out_ready
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int N_TERMS = MAC_N_TERMS_DEF,
  parameter int ACC_W   = MAC_ACC_W_DEF
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [MAC_PROD_W-1:0] product,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_W-1:0]      acc_sum,
  output logic                  overflow,
  output logic [7:0]            term_cnt
);

  mac_state_e       state, state_nxt;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic             ovf, ovf_nxt;
  logic [ACC_W:0]   sum_ext;
  logic             accept;
  logic             last_term;

  assign in_ready  = (state == ST_ACCUM) && !clear;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == ST_DONE);
  assign acc_sum   = acc;
  assign overflow  = ovf;

  // Extra top bit captures the carry out of the ACC_W-bit sum.
  assign sum_ext = {1'b0, acc} + (ACC_W + 1)'(product);

  mac_term_counter #(
    .N_TERMS(N_TERMS)
  ) u_term_counter (
    .clk (clk),
    .rstn(rstn),
    .clr (clear),
    .inc (accept),
    .cnt (term_cnt),
    .last(last_term)
  );

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    ovf_nxt   = ovf;
    if (clear) begin
      state_nxt = ST_ACCUM;
      acc_nxt   = '0;
      ovf_nxt   = 1'b0;
    end else begin
      case (state)
        ST_ACCUM: begin
          if (accept) begin
            acc_nxt = sum_ext[ACC_W-1:0];
            ovf_nxt = ovf | sum_ext[ACC_W];
            if (last_term) state_nxt = ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_nxt = ST_ACCUM;
            acc_nxt   = '0;
            ovf_nxt   = 1'b0;
          end
        end
        default: state_nxt = ST_ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_ACCUM;
      acc   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      ovf   <= ovf_nxt;
    end
  end

endmodule

// File: doc/mac_accumulator.md
# mac_accumulator

Downstream stage of the 4-bit array multiplier. Accepts a stream of 8-bit products over a valid/ready handshake and sums a fixed number of them into a wide accumulator. Presents each completed sum with a sticky overflow flag on an output valid/ready handshake. Together the two blocks form a dot-product / multiply-accumulate datapath.

## Interface
Parameters:
- `N_TERMS`, default 4: number of products summed per frame; legal range 1..255.
- `ACC_W`, default 16: accumulator and output width; legal range 8..32.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rstn`  in  1  reset, asynchronous and active-low.
- `clear`  in  1  synchronous abort: drop the current frame and zero all state.
- `in_valid`  in  1  `product` is valid this cycle.
- `in_ready`  out  1  block accepts a product this cycle.
- `product`  in  8  unsigned product from the multiplier.
- `out_valid`  out  1  `acc_sum` and `overflow` hold a completed frame.
- `out_ready`  in  1  consumer takes the frame this cycle.
- `acc_sum`  out  ACC_W  frame sum, modulo 2^ACC_W.
- `overflow`  out  1  at least one carry out of ACC_W bits occurred in this frame.
- `term_cnt`  out  8  products accepted so far in the current frame.

## Operation
The block has two states:
- **ACCUM**
  - `in_ready` = !clear.
  - An accept is `in_valid && in_ready`. On each accept: `acc <= acc + product`, with `product` zero-extended to ACC_W bits.
  - The carry out of bit ACC_W-1 ORs into `overflow`.
  - `term_cnt` increments.
  - On the accept where `term_cnt == N_TERMS-1`, go to DONE and reset `term_cnt` to 0.
- **DONE**
  - `in_ready` = 0 and `out_valid` = 1.
  - `acc_sum` and `overflow` are frozen.
  - On `out_valid && out_ready`: go to ACCUM, and zero `acc` and `overflow`.
- **clear** (either state): go to ACCUM, zero `acc`, `overflow` and `term_cnt`. `clear` has priority over any handshake in the same cycle. A product presented in that cycle is not accepted, because `in_ready` is 0. A pending output is discarded.
- **Reset values**: state = ACCUM, `acc_sum` = 0, `overflow` = 0, `term_cnt` = 0, `out_valid` = 0. `in_ready` = 1 after reset, provided `clear` = 0.
- **Arithmetic**: unsigned only. The sum wraps modulo 2^ACC_W. `overflow` is sticky within a frame and never self-clears before the output handshake.
- **N_TERMS = 1**: every accept goes directly to DONE.
- No bypass: a new frame cannot start while DONE is pending, so there is no overlap of output and input handshakes.

## Timing
- `in_ready`, `out_valid`, `acc_sum`, `overflow` and `term_cnt` are registered. The only exception is the `!clear` term in `in_ready`, which is combinational from `clear`.
- Latency: `out_valid` rises on the clock edge that accepts the Nth product, so it is visible in the following cycle.
- Throughput: one product per cycle while in ACCUM. Each frame then spends at least one cycle in DONE, so one frame takes at least N_TERMS+1 cycles.
- Output hold: `out_valid` stays high, and `acc_sum` stays stable, until a cycle with `out_ready` = 1. `in_ready` rises in the cycle after that output handshake.
- Asynchronous reset takes effect immediately, mid-frame or mid-DONE. All outputs go to their reset values without waiting for a clock edge.
- `in_valid` may drop between products. An idle cycle does not change any state.

## Structure
- A shared package `mac_pkg` holds:
  - the state encoding (`ST_ACCUM`, `ST_DONE`, a 1-bit encoding);
  - the default constants `MAC_N_TERMS_DEF` = 4 and `MAC_ACC_W_DEF` = 16;
  - the product width constant `MAC_PROD_W` = 8, shared with the multiplier.
- One sub-module is natural: `mac_term_counter`, an 8-bit counter with increment, synchronous clear, and a `last` flag decoded for N_TERMS-1.
- The adder and overflow logic stay inline in `mac_accumulator`.

## Test plan
All scenarios use the defaults (N_TERMS=4, ACC_W=16) unless stated otherwise.
- **Basic frame:** after reset, drive products 225, 225, 225, 225 on consecutive cycles with `out_ready`=1 -> `out_valid` is high for 1 cycle, `acc_sum`=900, `overflow`=0, `term_cnt` returns to 0, and `in_ready` is high again in the next cycle.
- **Backpressure:** products 1, 2, 3, 4 with `out_ready`=0 for 5 cycles -> `out_valid` holds with `acc_sum`=10 and `in_ready`=0 throughout. A 5th product held on `in_valid` is not accepted. After `out_ready` rises, the next frame starts at 0.
- **Overflow (ACC_W=9):** four products of 225 -> `acc_sum`=388 (900 mod 512) and `overflow`=1. The next frame of 1, 1, 1, 1 gives 4 with `overflow`=0.
- **Clear mid-frame:** products 50, 60, then `clear` asserted together with `in_valid` and product 70 -> 70 is not accepted, and `term_cnt`=0. The following products 5, 5, 5, 5 give `acc_sum`=20.
- **Reset mid-DONE:** complete a frame, hold `out_ready`=0, then pulse `rstn` low between clock edges -> `out_valid`, `acc_sum` and `overflow` go to 0 immediately, and `in_ready` is 1 after release.
- **Gapped input (N_TERMS=1):** products 7, then idle for 3 cycles, then 9 -> two separate frames with `acc_sum` 7 and then 9, each completing one cycle after its accept.
